button_pio_event_ctrl: RTL and testbench

- Avalon-MM master that services the 2-bit button PIO slave (data reg at address 0, irq mask at 2, edge capture at 3) on behalf of hardware consumers, with no Nios involvement.
- On power-up it programs the irq mask; on each PIO irq it reads edge capture, clears it, samples the input levels and queues one event word.
- Events drain through a valid/ready FIFO interface; overflows are counted.
- Sits beside the button PIO in EthernetSystem, driving its s1 port through the interconnect as a second master.

---
 rtl/button_pio_event_ctrl.sv | 168 ++++++++++++++++
 tb/tb_button_pio_event_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_pio_event_ctrl.sv
// Avalon-MM master servicing a button PIO: programs the irq mask, services edge
// interrupts and queues {edges, levels} events into a first-word-fall-through FIFO.
module button_pio_event_ctrl #(
  parameter int               WIDTH      = 2,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT_MASK  = 2'b11
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  input  logic [WIDTH-1:0] mask_value,
  input  logic             mask_load,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic             busy,
  output logic [7:0]       overflow_count,
  input  logic             overflow_clr
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PAD = 32 - WIDTH;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_MASK, S_RD_EDGE, S_WAIT_EDGE,
    S_CLR_EDGE, S_RD_DATA, S_WAIT_DATA, S_PUSH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] edges_q;
  logic [WIDTH-1:0] levels_q;
  logic             mask_pending;
  logic [WIDTH-1:0] mask_latch;

  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               fifo_full;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic [2*WIDTH-1:0] head;

  // Upper read-data bits are don't-care for a WIDTH-bit PIO.
  logic unused_readdata;
  assign unused_readdata = ^pio_readdata[31:WIDTH];

  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign evt_valid = (wr_ptr != rd_ptr);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign evt_edges = head[2*WIDTH-1:WIDTH];
  assign evt_level = head[WIDTH-1:0];
  assign pop       = evt_valid && evt_ready;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push_ok   = (state == S_PUSH) && (!fifo_full || pop);
  assign drop      = (state == S_PUSH) && fifo_full && !pop;
  assign busy      = (state != S_IDLE);

  // Bus outputs are registered on the edge that enters the state owning the access,
  // so each access is visible for exactly the cycle spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_INIT;
      edges_q        <= '0;
      levels_q       <= '0;
      mask_pending   <= 1'b0;
      mask_latch     <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= ADDR_DATA;
      pio_writedata  <= '0;
    end else begin
      // NOTE: later non-blocking assignments in this block override these idle defaults.
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= ADDR_DATA;
      pio_writedata  <= '0;

      if (state != S_IDLE && mask_load) begin
        mask_pending <= 1'b1;
        mask_latch   <= mask_value;
      end

      case (state)
        S_INIT: begin
          pio_chipselect <= 1'b1;
          pio_write_n    <= 1'b0;
          pio_address    <= ADDR_MASK;
          pio_writedata  <= {{PAD{1'b0}}, INIT_MASK};
          state          <= S_IDLE;
        end
        S_IDLE: begin
          if (mask_pending || mask_load) begin
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_address    <= ADDR_MASK;
            pio_writedata  <= {{PAD{1'b0}}, (mask_load ? mask_value : mask_latch)};
            mask_pending   <= 1'b0;
            state          <= S_MASK;
          end else if (pio_irq) begin
            pio_chipselect <= 1'b1;
            pio_address    <= ADDR_EDGE;
            state          <= S_RD_EDGE;
          end
        end
        S_MASK:    state <= S_IDLE;
        S_RD_EDGE: state <= S_WAIT_EDGE;
        S_WAIT_EDGE: begin
          edges_q <= pio_readdata[WIDTH-1:0];
          if (pio_readdata[WIDTH-1:0] == '0) begin
            state <= S_IDLE;
          end else begin
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            pio_address    <= ADDR_EDGE;
            state          <= S_CLR_EDGE;
          end
        end
        S_CLR_EDGE: begin
          pio_chipselect <= 1'b1;
          pio_address    <= ADDR_DATA;
          state          <= S_RD_DATA;
        end
        S_RD_DATA: state <= S_WAIT_DATA;
        S_WAIT_DATA: begin
          levels_q <= pio_readdata[WIDTH-1:0];
          state    <= S_PUSH;
        end
        S_PUSH:  state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; only the pointers are cleared, which empties it.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {edges_q, levels_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || overflow_clr) begin
      overflow_count <= '0;
    end else if (drop && overflow_count != 8'hFF) begin
      overflow_count <= overflow_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_button_pio_event_ctrl.sv
// Directed bench for button_pio_event_ctrl with a behavioural button PIO slave.
module tb_button_pio_event_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata = '0;
  logic        pio_irq;
  logic [1:0]  mask_value = '0;
  logic        mask_load = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [1:0]  evt_edges;
  logic [1:0]  evt_level;
  logic        busy;
  logic [7:0]  overflow_count;
  logic        overflow_clr = 1'b0;

  always #5 clk = ~clk;

  button_pio_event_ctrl #(.WIDTH(2), .FIFO_DEPTH(4), .INIT_MASK(2'b11)) dut (
    .clk(clk), .reset(reset),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .mask_value(mask_value), .mask_load(mask_load),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_edges(evt_edges), .evt_level(evt_level),
    .busy(busy), .overflow_count(overflow_count), .overflow_clr(overflow_clr)
  );

  // Behavioural PIO: registered read data, edge capture cleared by any write to addr 3.
  logic [1:0] pio_in = '0;
  logic [1:0] cap = '0;
  logic [1:0] cap_set = '0;
  logic [1:0] pmask = '0;
  logic       irq_force = 1'b0;

  assign pio_irq = (|(cap & pmask)) | irq_force;

  always @(posedge clk) begin
    if (pio_chipselect && pio_write_n) begin
      case (pio_address)
        2'd0:    pio_readdata <= {30'h2AAAAAAA, pio_in};
        2'd2:    pio_readdata <= {30'h0, pmask};
        2'd3:    pio_readdata <= {30'h15555555, cap};
        default: pio_readdata <= 32'h0;
      endcase
    end else begin
      pio_readdata <= 32'h0;
    end
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pmask <= pio_writedata[1:0];
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3) cap <= 2'b00;
    else cap <= cap | cap_set;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
  } bus_rec_t;
  bus_rec_t log_q[$];

  always @(negedge clk) begin
    if (pio_chipselect) log_q.push_back('{cyc, !pio_write_n, pio_address, pio_writedata});
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rec(input string name, input int idx, input int ecyc,
                           input logic ewr, input logic [1:0] ea, input logic [31:0] ewd);
    if (idx >= log_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: only %0d bus accesses, expected entry %0d", name, log_q.size(), idx);
    end else begin
      check({name, "_cyc"}, 64'(log_q[idx].cyc), 64'(ecyc));
      check({name, "_acc"}, {log_q[idx].wr, log_q[idx].addr, log_q[idx].wd}, {ewr, ea, ewd});
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Pulses button edges in the current cycle m; the irq is high in cycle m+1.
  task automatic edge_at(input logic [1:0] bits, output int m);
    @(negedge clk);
    m = cyc;
    cap_set = bits;
    @(negedge clk);
    cap_set = '0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!evt_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(evt_valid), 64'd1);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0] cap_bits;
    logic [1:0] in_lvl;
    logic [1:0] exp_edges;
    logic [1:0] exp_level;
  } vec_t;

  vec_t vecs[5];
  logic [1:0] caps[5];
  logic [1:0] lvls[5];

  initial begin
    int m, n;
    vecs[0] = '{2'b01, 2'b01, 2'b01, 2'b01};
    vecs[1] = '{2'b10, 2'b10, 2'b10, 2'b10};
    vecs[2] = '{2'b11, 2'b00, 2'b11, 2'b00};
    vecs[3] = '{2'b01, 2'b10, 2'b01, 2'b10};
    vecs[4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    caps = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    lvls = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};

    // Reset, then the INIT mask write one cycle after release.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_cs", 64'(pio_chipselect), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_valid", 64'(evt_valid), 64'd0);
    check("rst_ovf", 64'(overflow_count), 64'd0);
    @(negedge clk);
    check("init_wr", {pio_chipselect, pio_write_n, pio_address, pio_writedata},
          {1'b1, 1'b0, 2'd2, 32'h3});
    check("init_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("idle_cs", 64'(pio_chipselect), 64'd0);
    repeat (3) @(negedge clk);

    // Basic service sequence timing.
    pio_in = 2'b01;
    log_q.delete();
    edge_at(2'b01, m);
    n = m + 1;
    goto(n + 6);
    check("basic_valid_n6", 64'(evt_valid), 64'd0);
    goto(n + 7);
    check("basic_valid_n7", 64'(evt_valid), 64'd1);
    check("basic_edges", 64'(evt_edges), 64'h1);
    check("basic_level", 64'(evt_level), 64'h1);
    goto(n + 10);
    check("basic_nacc", 64'(log_q.size()), 64'd3);
    check_rec("basic_rd3", 0, n + 1, 1'b0, 2'd3, 32'h0);
    check_rec("basic_clr", 1, n + 3, 1'b1, 2'd3, 32'h0);
    check_rec("basic_rd0", 2, n + 4, 1'b0, 2'd0, 32'h0);
    pulse_ready();
    check("basic_drained", 64'(evt_valid), 64'd0);

    // Spurious irq: edge capture reads back zero.
    log_q.delete();
    @(negedge clk);
    n = cyc;
    irq_force = 1'b1;
    @(negedge clk);
    irq_force = 1'b0;
    goto(n + 2);
    check("spur_busy_n2", 64'(busy), 64'd1);
    goto(n + 3);
    check("spur_busy_n3", 64'(busy), 64'd0);
    goto(n + 10);
    check("spur_nacc", 64'(log_q.size()), 64'd1);
    check_rec("spur_rd3", 0, n + 1, 1'b0, 2'd3, 32'h0);
    check("spur_valid", 64'(evt_valid), 64'd0);

    // Table of single events with immediate consumption.
    for (int i = 0; i < 5; i++) begin
      pio_in = vecs[i].in_lvl;
      edge_at(vecs[i].cap_bits, m);
      wait_valid($sformatf("tbl%0d_valid", i));
      check($sformatf("tbl%0d_edges", i), 64'(evt_edges), 64'(vecs[i].exp_edges));
      check($sformatf("tbl%0d_level", i), 64'(evt_level), 64'(vecs[i].exp_level));
      pulse_ready();
      check($sformatf("tbl%0d_empty", i), 64'(evt_valid), 64'd0);
      repeat (3) @(negedge clk);
    end

    // Overflow: five events into a four-entry FIFO with no consumer.
    for (int i = 0; i < 5; i++) begin
      pio_in = lvls[i];
      edge_at(caps[i], m);
      repeat (10) @(negedge clk);
    end
    check("ovf_count", 64'(overflow_count), 64'd1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("ovf_clr", 64'(overflow_count), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_q%0d", i), {evt_valid, evt_edges, evt_level}, {1'b1, caps[i], lvls[i]});
      pulse_ready();
    end
    check("ovf_empty", 64'(evt_valid), 64'd0);

    // Full FIFO with a pop exactly in the PUSH cycle.
    for (int i = 0; i < 4; i++) begin
      pio_in = lvls[i];
      edge_at(caps[i], m);
      repeat (10) @(negedge clk);
    end
    pio_in = lvls[4];
    edge_at(caps[4], m);
    n = m + 1;
    goto(n + 6);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("fullpop_ovf", 64'(overflow_count), 64'd0);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("fullpop_q%0d", i), {evt_valid, evt_edges, evt_level}, {1'b1, caps[i], lvls[i]});
      pulse_ready();
    end
    check("fullpop_empty", 64'(evt_valid), 64'd0);

    // mask_load during RD_DATA is deferred until after PUSH.
    evt_ready = 1'b1;
    log_q.delete();
    pio_in = 2'b10;
    edge_at(2'b01, m);
    n = m + 1;
    goto(n + 4);
    mask_value = 2'b10;
    mask_load = 1'b1;
    @(negedge clk);
    mask_load = 1'b0;
    goto(n + 12);
    check("mdef_nacc", 64'(log_q.size()), 64'd4);
    check_rec("mdef_rd3", 0, n + 1, 1'b0, 2'd3, 32'h0);
    check_rec("mdef_clr", 1, n + 3, 1'b1, 2'd3, 32'h0);
    check_rec("mdef_rd0", 2, n + 4, 1'b0, 2'd0, 32'h0);
    check_rec("mdef_mask", 3, n + 8, 1'b1, 2'd2, 32'h2);

    // mask_load and irq together in IDLE: mask write first.
    log_q.delete();
    edge_at(2'b10, m);
    n = m + 1;
    mask_value = 2'b11;
    mask_load = 1'b1;
    @(negedge clk);
    mask_load = 1'b0;
    goto(n + 14);
    check("mirq_nacc", 64'(log_q.size()), 64'd4);
    check_rec("mirq_mask", 0, n + 1, 1'b1, 2'd2, 32'h3);
    check_rec("mirq_rd3", 1, n + 3, 1'b0, 2'd3, 32'h0);
    check_rec("mirq_clr", 2, n + 5, 1'b1, 2'd3, 32'h0);
    check_rec("mirq_rd0", 3, n + 6, 1'b0, 2'd0, 32'h0);
    evt_ready = 1'b0;

    // Reset mid-sequence discards the FIFO and reruns INIT.
    pio_in = 2'b01;
    edge_at(2'b01, m);
    repeat (10) @(negedge clk);
    check("mrst_pre_valid", 64'(evt_valid), 64'd1);
    edge_at(2'b10, m);
    n = m + 1;
    goto(n + 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_valid", 64'(evt_valid), 64'd0);
    check("mrst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("mrst_init_wr", {pio_chipselect, pio_write_n, pio_address, pio_writedata},
          {1'b1, 1'b0, 2'd2, 32'h3});
    wait_valid("mrst_resvc_valid");
    check("mrst_resvc", {evt_edges, evt_level}, {2'b10, 2'b01});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
